seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector. Generalises the fixed-pattern lab2_prob1 detector.
- Pattern length and value are set by parameters. Overlap and non-overlap mode is a runtime input.
- Adds an input enable, a match counter with synchronous clear, and a progress output S equal to the number of pattern bits currently matched.
- Sits directly after a serial bit source (switch or debounced input); V drives an LED or a downstream event counter.

Parameters:
- PATTERN_LEN, 4, number of bits in the pattern; legal range 2..16.
- PATTERN, 4'b1011, pattern value; bit PATTERN_LEN-1 is the first bit expected on X.
- CNT_W, 8, width of match_count.
- SW, $clog2(PATTERN_LEN+1), width of S; derived, not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample enable; X is consumed only on edges where en=1.
- X  in  1  serial data bit.
- ovl  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on enabled edges.
- cnt_clr  in  1  synchronous clear of match_count.
- S  out  SW  matched-prefix length, 0..PATTERN_LEN.
- V  out  1  one-cycle detect pulse.
- match_count  out  CNT_W  saturating count of detections.

Behaviour:
- Reset (rst=1 at an edge): history empty (valid count 0), S=0, V=0, match_count=0. rst overrides en, cnt_clr and everything else, including mid-sequence.
- State registers:
  - hist: PATTERN_LEN-bit shift register, newest bit at LSB.
  - vcnt: number of valid history bits, 0..PATTERN_LEN, saturating.
  - v_r: the V register.
- Enabled edge (en=1, rst=0):
  - Non-overlap case (ovl=0 and S==PATTERN_LEN before the edge): history is treated as empty before the shift, so vcnt becomes 1 and hist holds only the new X.
  - Otherwise hist shifts in X and vcnt increments, saturating at PATTERN_LEN.
- S: Moore function of registers. S = largest k ≤ vcnt such that the k newest hist bits equal PATTERN[PATTERN_LEN-1 -: k]. k=0 always qualifies.
- V:
  - v_r is set at an enabled edge whose next-state S equals PATTERN_LEN; cleared at every other edge.
  - Effective latency: V is high in the cycle after the edge that sampled the final pattern bit, for exactly one cycle.
  - Back-to-back detections in overlap mode give consecutive V pulses.
- en=0: hist, vcnt and S hold; V drops to 0 at that edge; match_count does not increment.
- match_count:
  - Increments at the same edge that sets v_r.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 clears it. If a detection occurs on the same edge, the result is 1, not 0.
- ovl changes take effect at the next enabled edge. No other state is affected.
- X is not synchronised inside this block; the caller provides a synchronous X.

Decomposition:
- Package seq_det_pkg:
  - clog2 helper function.
  - Localparam range checks for PATTERN_LEN (elaboration error outside 2..16).
- One sub-module, prefix_match: purely combinational. Inputs hist, vcnt and PATTERN; output S. It uses a generate loop over k comparing masked suffixes, then a priority select of the largest k.
- The top level holds hist, vcnt, v_r, match_count and the enable/mode logic.

Test Plan:
- Reset then X=1,0,1,1 with en=1, ovl=1, defaults -> S=1,2,3,4; V=1 only in the cycle after the 4th edge; match_count=1.
- Overlap, X=1,0,1,1,0,1,1 -> S=1,2,3,4,2,3,4; V pulses after edges 4 and 7; match_count=2.
- Non-overlap, same stream -> S=1,2,3,4,0,1,1; single V pulse; match_count=1.
- Hold and reset:
  - Feed 1,0,1, deassert en for 3 cycles while toggling X -> S stays 3, V=0. Re-enable with X=1 -> S=4, V pulse.
  - Repeat with rst=1 asserted after 1,0,1 -> S=0; next X=1 gives S=1.
- Counter (CNT_W=2, overlap, pattern repeated 5 times) -> match_count 1,2,3,3,3.
  - cnt_clr on the edge of the 6th match -> match_count=1.
  - cnt_clr on a non-match edge -> match_count=0.
- PATTERN_LEN=6, PATTERN=6'b110110, overlap, X=1,1,0,1,1,0,1,1,0 -> V pulses after edges 6 and 9; S after edge 9 = 6.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//   clog2      : ceiling log2 used to size the progress output
//   len_ok     : true when a pattern length lies in the supported range
package seq_det_pkg;

  localparam int unsigned MIN_PATTERN_LEN = 2;
  localparam int unsigned MAX_PATTERN_LEN = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic bit len_ok(input int unsigned len);
    return (len >= MIN_PATTERN_LEN) && (len <= MAX_PATTERN_LEN);
  endfunction

endpackage

// File: rtl/seq_detector_param_prefix_match.sv
// Combinational matched-prefix length.
//   hist : history bits, newest at LSB
//   vcnt : number of valid history bits
//   s    : largest k <= vcnt whose k newest bits equal the first k pattern bits
module prefix_match
  import seq_det_pkg::*;
#(
  parameter int unsigned                   PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0]        PATTERN     = 4'b1011,
  parameter int unsigned                   SW          = clog2(PATTERN_LEN + 1)
) (
  input  logic [PATTERN_LEN-1:0] hist,
  input  logic [SW-1:0]          vcnt,
  output logic [SW-1:0]          s
);

  logic [PATTERN_LEN:1] ok;

  // ok[k]: the k newest history bits are valid and equal the pattern's leading k bits.
  for (genvar k = 1; k <= PATTERN_LEN; k++) begin : g_k
    localparam logic [PATTERN_LEN-1:0] MASK = PATTERN_LEN'((64'd1 << k) - 64'd1);
    localparam logic [PATTERN_LEN-1:0] WANT = PATTERN >> (PATTERN_LEN - k);
    assign ok[k] = (vcnt >= SW'(k)) && (((hist ^ WANT) & MASK) == '0);
  end

  // Ascending scan so the largest qualifying k wins; k = 0 is the fallback.
  always_comb begin
    s = '0;
    for (int k = 1; k <= int'(PATTERN_LEN); k++) begin
      if (ok[k]) s = SW'(k);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-sequence detector with overlap control and match counter.
//   clk, rst    : clock, synchronous active-high reset
//   en          : sample enable, X consumed only when high
//   X           : serial data bit (already synchronous)
//   ovl         : 1 = overlapping detection, 0 = restart after a full match
//   cnt_clr     : synchronous clear of match_count
//   S           : matched-prefix length 0..PATTERN_LEN (function of registers)
//   V           : one-cycle detect pulse, registered
//   match_count : saturating detection count
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned            PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int unsigned            CNT_W       = 8,
  parameter int unsigned            SW          = clog2(PATTERN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             X,
  input  logic             ovl,
  input  logic             cnt_clr,
  output logic [SW-1:0]    S,
  output logic             V,
  output logic [CNT_W-1:0] match_count
);

  if (!len_ok(PATTERN_LEN)) begin : g_bad_len
    $error("seq_detector_param: PATTERN_LEN must be within 2..16");
  end

  logic [PATTERN_LEN-1:0] hist, hist_nxt;
  logic [SW-1:0]          vcnt, vcnt_nxt;
  logic [SW-1:0]          s_cur;
  logic                   v_r;
  logic                   restart, hit, detect;

  prefix_match #(
    .PATTERN_LEN (PATTERN_LEN),
    .PATTERN     (PATTERN),
    .SW          (SW)
  ) u_prefix_match (
    .hist (hist),
    .vcnt (vcnt),
    .s    (s_cur)
  );

  // Next history: a completed match in non-overlap mode empties the history first.
  always_comb begin
    restart  = !ovl && (s_cur == SW'(PATTERN_LEN));
    hist_nxt = {hist[PATTERN_LEN-2:0], X};
    vcnt_nxt = (vcnt == SW'(PATTERN_LEN)) ? vcnt : vcnt + SW'(1);
    if (restart) begin
      hist_nxt = {{(PATTERN_LEN-1){1'b0}}, X};
      vcnt_nxt = SW'(1);
    end
    // Next-state S reaches PATTERN_LEN exactly when the full window equals the pattern.
    hit    = (vcnt_nxt == SW'(PATTERN_LEN)) && (hist_nxt == PATTERN);
    detect = en && hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist        <= '0;
      vcnt        <= '0;
      v_r         <= 1'b0;
      match_count <= '0;
    end else begin
      if (en) begin
        hist <= hist_nxt;
        vcnt <= vcnt_nxt;
      end
      v_r <= detect;
      // A clear coinciding with a detection leaves the new detection counted.
      if (cnt_clr) begin
        match_count <= detect ? CNT_W'(1) : '0;
      end else if (detect && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  assign S = s_cur;
  assign V = v_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: table vectors and corner sequences against constants,
// every cycle of every instance against a prefix-matching reference model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0, x = 1'b0, ovl = 1'b1, cnt_clr = 1'b0;

  logic [2:0] s0, s1, s2;
  logic       v0, v1, v2;
  logic [7:0] c0;
  logic [1:0] c1;
  logic [7:0] c2;

  int nchk = 0;
  int nfail = 0;

  // Instance 0: defaults. Instance 1: 2-bit counter. Instance 2: 6-bit pattern.
  seq_detector_param u_dut0 (
    .clk(clk), .rst(rst), .en(en), .X(x), .ovl(ovl), .cnt_clr(cnt_clr),
    .S(s0), .V(v0), .match_count(c0));

  seq_detector_param #(.CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .X(x), .ovl(ovl), .cnt_clr(cnt_clr),
    .S(s1), .V(v1), .match_count(c1));

  seq_detector_param #(.PATTERN_LEN(6), .PATTERN(6'b110110)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .X(x), .ovl(ovl), .cnt_clr(cnt_clr),
    .S(s2), .V(v2), .match_count(c2));

  // Reference model: bits seen since the last restart, with plain integer arithmetic.
  int m_len  [3] = '{4, 4, 6};
  int m_pat  [3] = '{11, 11, 54};
  int m_cmax [3] = '{255, 3, 255};
  int m_bits [3];
  int m_n    [3];
  int m_cnt  [3];
  int m_v    [3];

  // Longest prefix of the pattern that ends the observed bit stream.
  function automatic int model_s(input int bits, input int n, input int len, input int pat);
    for (int k = n; k > 0; k--) begin
      if ((bits % (1 << k)) == (pat >> (len - k))) return k;
    end
    return 0;
  endfunction

  task automatic model_update(input logic r, input logic e, input logic xx,
                              input logic o, input logic c);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_bits[i] = 0; m_n[i] = 0; m_cnt[i] = 0; m_v[i] = 0;
      end else if (e) begin
        if (!o && model_s(m_bits[i], m_n[i], m_len[i], m_pat[i]) == m_len[i]) begin
          m_bits[i] = 0; m_n[i] = 0;
        end
        m_bits[i] = (m_bits[i] * 2 + int'(xx)) % (1 << m_len[i]);
        if (m_n[i] < m_len[i]) m_n[i]++;
        m_v[i] = (model_s(m_bits[i], m_n[i], m_len[i], m_pat[i]) == m_len[i]) ? 1 : 0;
        if (c) m_cnt[i] = m_v[i];
        else if (m_v[i] == 1 && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
      end else begin
        m_v[i] = 0;
        if (c) m_cnt[i] = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_compare();
    check("model_s0", int'(s0), model_s(m_bits[0], m_n[0], m_len[0], m_pat[0]));
    check("model_v0", int'(v0), m_v[0]);
    check("model_c0", int'(c0), m_cnt[0]);
    check("model_s1", int'(s1), model_s(m_bits[1], m_n[1], m_len[1], m_pat[1]));
    check("model_v1", int'(v1), m_v[1]);
    check("model_c1", int'(c1), m_cnt[1]);
    check("model_s2", int'(s2), model_s(m_bits[2], m_n[2], m_len[2], m_pat[2]));
    check("model_v2", int'(v2), m_v[2]);
    check("model_c2", int'(c2), m_cnt[2]);
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic xx,
                      input logic o, input logic c);
    @(negedge clk);
    rst = r; en = e; x = xx; ovl = o; cnt_clr = c;
    @(posedge clk);
    #1;
    model_update(r, e, xx, o, c);
    model_compare();
  endtask

  typedef struct {
    logic r, e, x, o, c;
    int   s, v, cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic xx, input logic o,
                     input logic c, input int s, input int v, input int cnt);
    vec_t t;
    t.r = r; t.e = e; t.x = xx; t.o = o; t.c = c; t.s = s; t.v = v; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  initial begin
    logic o_r;

    // Basic detection, then an idle edge drops V.
    add(1,0,0,1,0, 0,0,0);
    add(0,1,1,1,0, 1,0,0); add(0,1,0,1,0, 2,0,0); add(0,1,1,1,0, 3,0,0);
    add(0,1,1,1,0, 4,1,1); add(0,0,0,1,0, 4,0,1);
    // Overlap stream 1011011, then clear on a non-match edge.
    add(1,0,0,1,0, 0,0,0);
    add(0,1,1,1,0, 1,0,0); add(0,1,0,1,0, 2,0,0); add(0,1,1,1,0, 3,0,0);
    add(0,1,1,1,0, 4,1,1); add(0,1,0,1,0, 2,0,1); add(0,1,1,1,0, 3,0,1);
    add(0,1,1,1,0, 4,1,2); add(0,1,0,1,1, 2,0,0);
    // Non-overlap on the same stream.
    add(1,0,0,0,0, 0,0,0);
    add(0,1,1,0,0, 1,0,0); add(0,1,0,0,0, 2,0,0); add(0,1,1,0,0, 3,0,0);
    add(0,1,1,0,0, 4,1,1); add(0,1,0,0,0, 0,0,1); add(0,1,1,0,0, 1,0,1);
    add(0,1,1,0,0, 1,0,1);
    // Enable hold with X toggling, then completion.
    add(1,0,0,1,0, 0,0,0);
    add(0,1,1,1,0, 1,0,0); add(0,1,0,1,0, 2,0,0); add(0,1,1,1,0, 3,0,0);
    add(0,0,0,1,0, 3,0,0); add(0,0,1,1,0, 3,0,0); add(0,0,0,1,0, 3,0,0);
    add(0,1,1,1,0, 4,1,1);
    // Mid-sequence reset overrides enable.
    add(1,0,0,1,0, 0,0,0);
    add(0,1,1,1,0, 1,0,0); add(0,1,0,1,0, 2,0,0); add(0,1,1,1,0, 3,0,0);
    add(1,1,1,1,0, 0,0,0); add(0,1,1,1,0, 1,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].x, vecs[i].o, vecs[i].c);
      check($sformatf("vec%0d_S", i), int'(s0), vecs[i].s);
      check($sformatf("vec%0d_V", i), int'(v0), vecs[i].v);
      check($sformatf("vec%0d_cnt", i), int'(c0), vecs[i].cnt);
    end

    // Saturating 2-bit counter, clear coinciding with the 6th detection, clear alone.
    begin
      int exp_cnt [6] = '{1, 2, 3, 3, 3, 1};
      logic [3:0] pat = 4'b1011;
      step(1, 0, 0, 1, 0);
      for (int rep = 0; rep < 6; rep++) begin
        for (int b = 3; b >= 0; b--) begin
          step(0, 1, pat[b], 1, (rep == 5 && b == 0) ? 1'b1 : 1'b0);
        end
        check($sformatf("sat_rep%0d_cnt", rep), int'(c1), exp_cnt[rep]);
        check($sformatf("sat_rep%0d_V", rep), int'(v1), 1);
      end
      step(0, 1, 0, 1, 1);
      check("clr_nonmatch_cnt", int'(c1), 0);
    end

    // 6-bit pattern with overlap: detections after edges 6 and 9.
    begin
      logic [8:0] bits = 9'b110110110;
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 9; i++) begin
        step(0, 1, bits[8 - i], 1, 0);
        check($sformatf("len6_edge%0d_V", i + 1), int'(v2), (i == 5 || i == 8) ? 1 : 0);
      end
      check("len6_final_S", int'(s2), 6);
      check("len6_final_cnt", int'(c2), 2);
    end

    // Randomised traffic on all instances against the model.
    o_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) o_r = ~o_r;
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           o_r,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
